// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding and the
// bit-counter width helper used by the serial arithmetic blocks.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // At least one bit, so the smallest legal width still has a counter.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR of their carries.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a (a),
      .b (b),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (cin),
      .s (s),
      .c (c1)
   );

   assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder: the basic arithmetic primitive.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first,
// with a start/busy/done handshake and registered sum/cout.
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_a_reg, shift_a_next;
   logic [WIDTH-1:0] shift_b_reg, shift_b_next;
   logic [WIDTH-1:0] shift_sum_reg, shift_sum_next;
   logic             carry_reg, carry_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic             cout_reg, cout_next;

   logic fa_s;
   logic fa_c;

   full_adder u_fa (
      .a    (shift_a_reg[0]),
      .b    (shift_b_reg[0]),
      .cin  (carry_reg),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_comb begin
      state_next     = state_reg;
      shift_a_next   = shift_a_reg;
      shift_b_next   = shift_b_reg;
      shift_sum_next = shift_sum_reg;
      carry_next     = carry_reg;
      cnt_next       = cnt_reg;
      sum_next       = sum_reg;
      cout_next      = cout_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               shift_a_next = a;
               shift_b_next = b;
               carry_next   = cin;
               cnt_next     = '0;
               state_next   = ST_RUN;
            end
         end
         ST_RUN: begin
            shift_a_next   = shift_a_reg >> 1;
            shift_b_next   = shift_b_reg >> 1;
            shift_sum_next = {fa_s, shift_sum_reg[WIDTH-1:1]};
            carry_next     = fa_c;
            cnt_next       = cnt_reg + CNT_W'(1);
            // Result registers change only on the edge that finishes the add.
            if (cnt_reg == CNT_LAST) begin
               sum_next   = {fa_s, shift_sum_reg[WIDTH-1:1]};
               cout_next  = fa_c;
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         shift_a_reg   <= '0;
         shift_b_reg   <= '0;
         shift_sum_reg <= '0;
         carry_reg     <= 1'b0;
         cnt_reg       <= '0;
         sum_reg       <= '0;
         cout_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_a_reg   <= shift_a_next;
         shift_b_reg   <= shift_b_next;
         shift_sum_reg <= shift_sum_next;
         carry_reg     <= carry_next;
         cnt_reg       <= cnt_next;
         sum_reg       <= sum_next;
         cout_reg      <= cout_next;
      end
   end

   assign busy = (state_reg == ST_RUN);
   assign done = (state_reg == ST_DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 against
// an arithmetic reference of a + b + cin.
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        cin8 = 1'b0;
   logic        busy8, done8, cout8;
   logic [7:0]  sum8;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        cin16 = 1'b0;
   logic        busy16, done16, cout16;
   logic [15:0] sum16;

   int checks = 0;
   int failures = 0;
   logic [8:0] last8 = '0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst   (rst),
      .start (start16),
      .a     (a16),
      .b     (b16),
      .cin   (cin16),
      .busy  (busy16),
      .done  (done16),
      .sum   (sum16),
      .cout  (cout16)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start8 = 1'b0;
      start16 = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      last8 = '0;
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags8 got busy=%0b done=%0b want 0 0", busy8, done8);
      end
      checks++;
      if ({cout8, sum8} !== 9'h000) begin
         failures++;
         $display("FAIL reset_result8 got=%03h want=000", {cout8, sum8});
      end
      checks++;
      if (busy16 !== 1'b0 || done16 !== 1'b0 || {cout16, sum16} !== 17'h0) begin
         failures++;
         $display("FAIL reset_state16 got busy=%0b done=%0b res=%05h want 0 0 00000",
                  busy16, done16, {cout16, sum16});
      end
      $display("txn reset busy=%0b done=%0b sum=%02h cout=%0b", busy8, done8, sum8, cout8);
   endtask

   // One 8-bit add; optionally pokes start at RUN cycle poke_at or asserts
   // rst at RUN cycle rst_at (aborting the add).
   task automatic run_add8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                           input int poke_at, input int rst_at, input string name);
      logic [8:0] expv;
      int done_cnt;
      int done_at;
      int busy_cnt;
      bit aborted;
      expv = {1'b0, ta} + {1'b0, tbv} + 9'(tc);
      done_cnt = 0;
      done_at = -1;
      busy_cnt = 0;
      aborted = 1'b0;
      a8 = ta;
      b8 = tbv;
      cin8 = tc;
      start8 = 1'b1;
      tick;
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      if (busy8) busy_cnt++;
      for (int n = 1; n <= 12; n++) begin
         if (n == poke_at) begin
            start8 = 1'b1;
            a8 = 8'hFF;
            b8 = 8'hFF;
         end else begin
            start8 = 1'b0;
         end
         if (n == rst_at) rst = 1'b1;
         tick;
         if (n == rst_at) begin
            rst = 1'b0;
            aborted = 1'b1;
            last8 = '0;
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== 9'h000) begin
               failures++;
               $display("FAIL %s_abort got busy=%0b done=%0b res=%03h want 0 0 000",
                        name, busy8, done8, {cout8, sum8});
            end
         end
         if (done8 === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
         end else if (busy8 === 1'b1) begin
            busy_cnt++;
         end
         if (done_at < 0 && done8 !== 1'b1) begin
            checks++;
            if ({cout8, sum8} !== last8) begin
               failures++;
               $display("FAIL %s_hold n=%0d got=%03h want=%03h", name, n, {cout8, sum8}, last8);
            end
         end
      end
      start8 = 1'b0;
      if (aborted) begin
         checks++;
         if (done_cnt != 0) begin
            failures++;
            $display("FAIL %s_nodone got=%0d pulses want=0", name, done_cnt);
         end
      end else begin
         checks++;
         if (done_cnt != 1 || done_at != 8) begin
            failures++;
            $display("FAIL %s_done got pulses=%0d at=%0d want 1 at 8", name, done_cnt, done_at);
         end
         checks++;
         if (busy_cnt != 8) begin
            failures++;
            $display("FAIL %s_busy got=%0d cycles want=8", name, busy_cnt);
         end
         checks++;
         if ({cout8, sum8} !== expv) begin
            failures++;
            $display("FAIL %s_result got=%03h want=%03h", name, {cout8, sum8}, expv);
         end
         last8 = expv;
      end
      $display("txn %s a=%02h b=%02h cin=%0b sum=%02h cout=%0b", name, ta, tbv, tc, sum8, cout8);
   endtask

   task automatic test_carry_ripple;
      run_add8(8'hFF, 8'h01, 1'b0, -1, -1, "ripple");
   endtask

   task automatic test_back_to_back;
      run_add8(8'hA5, 8'h5A, 1'b1, -1, -1, "seq1");
      run_add8(8'h7F, 8'h80, 1'b0, -1, -1, "seq2");
   endtask

   task automatic test_ignored_start;
      run_add8(8'h03, 8'h04, 1'b0, 3, -1, "ignore");
   endtask

   task automatic test_reset_mid_run;
      run_add8(8'h10, 8'h20, 1'b0, -1, 4, "abort");
      run_add8(8'h10, 8'h20, 1'b0, -1, -1, "restart");
   endtask

   // start held high: one accept every WIDTH+2 clocks.
   task automatic test_sweep8;
      logic [8:0] expv;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      start8 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick;
         expv = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         cin8 = 1'($urandom);
         for (int n = 1; n <= 9; n++) begin
            if (i == 199 && n == 9) start8 = 1'b0;
            tick;
            if (n == 8) begin
               checks++;
               if (done8 !== 1'b1 || {cout8, sum8} !== expv) begin
                  failures++;
                  $display("FAIL sweep8 i=%0d got done=%0b res=%03h want 1 %03h",
                           i, done8, {cout8, sum8}, expv);
               end
               $display("txn sweep8 i=%0d sum=%02h cout=%0b", i, sum8, cout8);
            end
         end
      end
      start8 = 1'b0;
   endtask

   task automatic test_sweep16;
      logic [16:0] expv;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      start16 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick;
         expv = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         cin16 = 1'($urandom);
         for (int n = 1; n <= 17; n++) begin
            if (i == 199 && n == 17) start16 = 1'b0;
            tick;
            if (n == 16) begin
               checks++;
               if (done16 !== 1'b1 || {cout16, sum16} !== expv) begin
                  failures++;
                  $display("FAIL sweep16 i=%0d got done=%0b res=%05h want 1 %05h",
                           i, done16, {cout16, sum16}, expv);
               end
               $display("txn sweep16 i=%0d sum=%04h cout=%0b", i, sum16, cout16);
            end
         end
      end
      start16 = 1'b0;
   endtask

   initial begin
      test_reset;
      test_carry_ripple;
      test_back_to_back;
      test_ignored_start;
      test_reset_mid_run;
      test_sweep8;
      test_sweep16;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
